// File: rtl/lsu_dcache_master.sv
// ---------------------------------------------------------------------------
// lsu_dcache_master
//
// Data-cache initiator for the Z480 load/store unit. It accepts one load or
// store micro-op at a time and checks its alignment. For stores it
// lane-shifts the data and builds byte strobes, then runs a single
// request/response exchange on the 64-bit dcache port. For loads it extracts
// the addressed bytes and sign- or zero-extends them. It then returns one
// tagged result to writeback. A watchdog turns a missing response into a
// timeout fault.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_op_*     / o_op_ready    micro-op from execute (valid/ready)
//   o_req_*    / i_req_ready   dcache request (registered)
//   i_rsp_*    / o_rsp_ready   dcache response
//   o_res_*    / i_res_ready   tagged result to writeback (registered)
//   o_busy                     FSM is not idle
//
// Parameter
//   TIMEOUT_CYCLES             WAIT cycles without a response before a
//                              timeout fault; 0 disables the watchdog
// ---------------------------------------------------------------------------
module lsu_dcache_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        i_op_valid,
  output logic        o_op_ready,
  input  logic        i_op_store,
  input  logic [1:0]  i_op_size,
  input  logic        i_op_signed,
  input  logic [63:0] i_op_addr,
  input  logic [63:0] i_op_wdata,
  input  logic [4:0]  i_op_tag,

  output logic        o_req_valid,
  input  logic        i_req_ready,
  output logic        o_req_write,
  output logic [63:0] o_req_addr,
  output logic [63:0] o_req_wdata,
  output logic [7:0]  o_req_wstrb,

  input  logic        i_rsp_valid,
  output logic        o_rsp_ready,
  input  logic [63:0] i_rsp_rdata,
  input  logic        i_rsp_fault,

  output logic        o_res_valid,
  input  logic        i_res_ready,
  output logic [63:0] o_res_data,
  output logic [4:0]  o_res_tag,
  output logic        o_res_fault,
  output logic [1:0]  o_res_cause,

  output logic        o_busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN = 2'd1;
  localparam logic [1:0] CAUSE_BUS      = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd3;

  localparam logic [31:0] LP_TIMEOUT = 32'(TIMEOUT_CYCLES);

  logic [1:0]  r_state;
  logic        r_stale;
  logic [31:0] r_wdogCnt;
  logic        r_store;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [2:0]  r_off;
  logic [4:0]  r_tag;

  logic        w_opFire;
  logic        w_rspFire;
  logic        w_misaligned;
  logic [7:0]  w_byteMask;
  logic [7:0]  w_wstrb;
  logic [63:0] w_wdata;
  logic [63:0] w_shifted;
  logic [63:0] w_loadData;
  logic        w_timeoutHit;

  // Stale marks an abandoned request whose late response must still be drained.
  assign o_op_ready  = (r_state == S_IDLE) && !r_stale;
  assign o_busy      = (r_state != S_IDLE);
  assign o_rsp_ready = (r_state == S_WAIT) || r_stale;

  assign w_opFire  = i_op_valid && o_op_ready;
  assign w_rspFire = i_rsp_valid && o_rsp_ready;

  always_comb begin
    w_misaligned = 1'b0;
    w_byteMask   = 8'h01;
    case (i_op_size)
      2'd0: begin w_misaligned = 1'b0;             w_byteMask = 8'h01; end
      2'd1: begin w_misaligned = i_op_addr[0];     w_byteMask = 8'h03; end
      2'd2: begin w_misaligned = |i_op_addr[1:0];  w_byteMask = 8'h0F; end
      default: begin w_misaligned = |i_op_addr[2:0]; w_byteMask = 8'hFF; end
    endcase
  end

  // Aligned ops never carry strobes or data past bit 63, so truncation is safe.
  assign w_wstrb = w_byteMask << i_op_addr[2:0];
  assign w_wdata = i_op_wdata << {i_op_addr[2:0], 3'b000};

  assign w_shifted = i_rsp_rdata >> {r_off, 3'b000};

  always_comb begin
    w_loadData = '0;
    case (r_size)
      2'd0: w_loadData = r_signed ? {{56{w_shifted[7]}},  w_shifted[7:0]}
                                  : {56'd0, w_shifted[7:0]};
      2'd1: w_loadData = r_signed ? {{48{w_shifted[15]}}, w_shifted[15:0]}
                                  : {48'd0, w_shifted[15:0]};
      2'd2: w_loadData = r_signed ? {{32{w_shifted[31]}}, w_shifted[31:0]}
                                  : {32'd0, w_shifted[31:0]};
      default: w_loadData = w_shifted;
    endcase
  end

  // The limit is reached on the WAIT cycle that would bring the count to
  // TIMEOUT_CYCLES, so WAIT lasts exactly TIMEOUT_CYCLES empty cycles.
  assign w_timeoutHit = (LP_TIMEOUT != 32'd0) && ((r_wdogCnt + 32'd1) == LP_TIMEOUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_stale     <= 1'b0;
      r_wdogCnt   <= '0;
      r_store     <= 1'b0;
      r_size      <= 2'd0;
      r_signed    <= 1'b0;
      r_off       <= 3'd0;
      r_tag       <= 5'd0;
      o_req_valid <= 1'b0;
      o_req_write <= 1'b0;
      o_req_addr  <= '0;
      o_req_wdata <= '0;
      o_req_wstrb <= '0;
      o_res_valid <= 1'b0;
      o_res_data  <= '0;
      o_res_tag   <= '0;
      o_res_fault <= 1'b0;
      o_res_cause <= CAUSE_NONE;
    end else begin
      // Stale can only be set outside WAIT, so this drain never races a live response.
      if (r_stale && w_rspFire) begin
        r_stale <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_opFire) begin
            r_store  <= i_op_store;
            r_size   <= i_op_size;
            r_signed <= i_op_signed;
            r_off    <= i_op_addr[2:0];
            r_tag    <= i_op_tag;
            if (w_misaligned) begin
              r_state     <= S_RESP;
              o_res_valid <= 1'b1;
              o_res_data  <= '0;
              o_res_tag   <= i_op_tag;
              o_res_fault <= 1'b1;
              o_res_cause <= CAUSE_MISALIGN;
            end else begin
              r_state     <= S_REQ;
              o_req_valid <= 1'b1;
              o_req_write <= i_op_store;
              o_req_addr  <= {i_op_addr[63:3], 3'b000};
              o_req_wdata <= w_wdata;
              o_req_wstrb <= w_wstrb;
            end
          end
        end

        S_REQ: begin
          if (i_req_ready) begin
            o_req_valid <= 1'b0;
            r_wdogCnt   <= '0;
            r_state     <= S_WAIT;
          end
        end

        S_WAIT: begin
          // A response arriving on the limit cycle takes priority over the timeout.
          if (i_rsp_valid) begin
            r_state     <= S_RESP;
            o_res_valid <= 1'b1;
            o_res_tag   <= r_tag;
            o_res_fault <= i_rsp_fault;
            o_res_cause <= i_rsp_fault ? CAUSE_BUS : CAUSE_NONE;
            o_res_data  <= (i_rsp_fault || r_store) ? 64'd0 : w_loadData;
          end else if (w_timeoutHit) begin
            r_state     <= S_RESP;
            r_stale     <= 1'b1;
            o_res_valid <= 1'b1;
            o_res_tag   <= r_tag;
            o_res_fault <= 1'b1;
            o_res_cause <= CAUSE_TIMEOUT;
            o_res_data  <= '0;
          end else begin
            r_wdogCnt <= r_wdogCnt + 32'd1;
          end
        end

        default: begin
          if (i_res_ready) begin
            o_res_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_dcache_master.sv
// ---------------------------------------------------------------------------
// tb_lsu_dcache_master
//
// Scenario-driven bench for lsu_dcache_master. Each test task drives one
// micro-op. When the op is driven it pushes the result it expects onto a
// queue, and it pops and compares that entry when the DUT presents the result.
// ---------------------------------------------------------------------------
module tb_lsu_dcache_master;

  localparam int unsigned TO = 4;

  typedef struct packed {
    logic [63:0] data;
    logic [4:0]  tag;
    logic        fault;
    logic [1:0]  cause;
  } res_t;

  logic        clk;
  logic        rst_n;
  logic        op_valid, op_ready, op_store, op_signed;
  logic [1:0]  op_size;
  logic [63:0] op_addr, op_wdata;
  logic [4:0]  op_tag;
  logic        req_valid, req_ready, req_write;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_fault;
  logic [63:0] rsp_rdata;
  logic        res_valid, res_ready, res_fault;
  logic [63:0] res_data;
  logic [4:0]  res_tag;
  logic [1:0]  res_cause;
  logic        busy;

  res_t actRes;
  res_t expQ[$];
  int   nChecks;
  int   nFails;

  assign actRes = {res_data, res_tag, res_fault, res_cause};

  lsu_dcache_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_op_valid  (op_valid),
    .o_op_ready  (op_ready),
    .i_op_store  (op_store),
    .i_op_size   (op_size),
    .i_op_signed (op_signed),
    .i_op_addr   (op_addr),
    .i_op_wdata  (op_wdata),
    .i_op_tag    (op_tag),
    .o_req_valid (req_valid),
    .i_req_ready (req_ready),
    .o_req_write (req_write),
    .o_req_addr  (req_addr),
    .o_req_wdata (req_wdata),
    .o_req_wstrb (req_wstrb),
    .i_rsp_valid (rsp_valid),
    .o_rsp_ready (rsp_ready),
    .i_rsp_rdata (rsp_rdata),
    .i_rsp_fault (rsp_fault),
    .o_res_valid (res_valid),
    .i_res_ready (res_ready),
    .o_res_data  (res_data),
    .o_res_tag   (res_tag),
    .o_res_fault (res_fault),
    .o_res_cause (res_cause),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL global_time_limit: simulation still running, required finish");
    $fatal(1, "[TB] time limit");
  end

  // Byte-by-byte reference extraction of a load from a doubleword.
  function automatic logic [63:0] model_load(logic [63:0] rdata, logic [2:0] off,
                                             logic [1:0] size, logic sgn);
    int n;
    logic [63:0] v;
    n = 1 << size;
    v = '0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rdata[8*(int'(off) + i) +: 8];
    if (sgn && v[8*n-1]) for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(logic st, logic [1:0] sz, logic sg, logic [63:0] a,
                          logic [63:0] wd, logic [4:0] tg);
    op_store  = st;
    op_size   = sz;
    op_signed = sg;
    op_addr   = a;
    op_wdata  = wd;
    op_tag    = tg;
    op_valid  = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    op_valid = 0; op_store = 0; op_size = 0; op_signed = 0;
    op_addr = 0; op_wdata = 0; op_tag = 0;
    req_ready = 0; rsp_valid = 0; rsp_rdata = 0; rsp_fault = 0; res_ready = 0;
    repeat (2) tick();
    nChecks++;
    if (op_ready !== 1'b1 || busy !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_ready_busy: op_ready=%b busy=%b, required op_ready=1 busy=0", op_ready, busy);
    end
    nChecks++;
    if ({req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready, res_valid,
         res_data, res_tag, res_fault, res_cause} !== '0) begin
      nFails++;
      $display("[TB] FAIL reset_outputs: req_v=%b req_addr=%h req_wdata=%h req_wstrb=%h rsp_ready=%b res=%h, required all 0",
               req_valid, req_addr, req_wdata, req_wstrb, rsp_ready, actRes);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_signed_byte_load();
    res_t e;
    drive_op(1'b0, 2'd0, 1'b1, 64'h1003, 64'h0, 5'd3);
    expQ.push_back('{data: model_load(64'h00000000_80000000, 3'd3, 2'd0, 1'b1),
                     tag: 5'd3, fault: 1'b0, cause: 2'd0});
    nChecks++;
    if (op_ready !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL byte_load_op_ready: got %b required 1", op_ready);
    end
    tick();
    op_valid = 1'b0;
    nChecks++;
    if ({req_valid, req_write, req_addr, req_wstrb} !== {1'b1, 1'b0, 64'h1000, 8'h08}) begin
      nFails++;
      $display("[TB] FAIL byte_load_req: valid=%b write=%b addr=%h wstrb=%h, required 1 0 %h 08",
               req_valid, req_write, req_addr, req_wstrb, 64'h1000);
    end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    nChecks++;
    if ({req_valid, rsp_ready, res_valid} !== 3'b010) begin
      nFails++;
      $display("[TB] FAIL byte_load_wait: req_v=%b rsp_ready=%b res_v=%b, required 0 1 0",
               req_valid, rsp_ready, res_valid);
    end
    rsp_valid = 1'b1;
    rsp_rdata = 64'h00000000_80000000;
    tick();
    rsp_valid = 1'b0;
    nChecks++;
    if (res_valid !== 1'b1 || expQ.size() == 0) begin
      nFails++;
      $display("[TB] FAIL byte_load_result: res_valid=%b queued=%0d, required res_valid=1 at N+3", res_valid, expQ.size());
    end else begin
      e = expQ.pop_front();
      if (actRes !== e || res_data !== 64'hFFFFFFFF_FFFFFF80) begin
        nFails++;
        $display("[TB] FAIL byte_load_result: got %h required %h", actRes, e);
      end
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    nChecks++;
    if (op_ready !== 1'b1 || res_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL byte_load_back_to_back: op_ready=%b res_valid=%b, required 1 0", op_ready, res_valid);
    end
  endtask

  task automatic test_half_store();
    res_t e;
    drive_op(1'b1, 2'd1, 1'b0, 64'h2006, 64'h0000_0000_0000_BEEF, 5'd7);
    expQ.push_back('{data: 64'd0, tag: 5'd7, fault: 1'b0, cause: 2'd0});
    tick();
    op_valid = 1'b0;
    nChecks++;
    if ({req_valid, req_write, req_wstrb, req_wdata, req_addr} !==
        {1'b1, 1'b1, 8'hC0, 64'hBEEF0000_00000000, 64'h2000}) begin
      nFails++;
      $display("[TB] FAIL half_store_req: valid=%b write=%b wstrb=%h wdata=%h addr=%h, required 1 1 c0 beef000000000000 2000",
               req_valid, req_write, req_wstrb, req_wdata, req_addr);
    end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_rdata = {$urandom, $urandom};
    tick();
    rsp_valid = 1'b0;
    nChecks++;
    if (res_valid !== 1'b1 || expQ.size() == 0) begin
      nFails++;
      $display("[TB] FAIL half_store_result: res_valid=%b queued=%0d, required 1", res_valid, expQ.size());
    end else begin
      e = expQ.pop_front();
      if (actRes !== e) begin
        nFails++;
        $display("[TB] FAIL half_store_result: got %h required %h", actRes, e);
      end
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_misaligned();
    res_t e;
    int sawReq;
    sawReq = 0;
    drive_op(1'b0, 2'd2, 1'b0, 64'h3002, 64'h0, 5'h15);
    expQ.push_back('{data: 64'd0, tag: 5'h15, fault: 1'b1, cause: 2'd1});
    tick();
    op_valid = 1'b0;
    if (req_valid !== 1'b0) sawReq++;
    nChecks++;
    if (res_valid !== 1'b1 || expQ.size() == 0) begin
      nFails++;
      $display("[TB] FAIL misaligned_result: res_valid=%b queued=%0d, required 1 at N+1", res_valid, expQ.size());
    end else begin
      e = expQ.pop_front();
      if (actRes !== e) begin
        nFails++;
        $display("[TB] FAIL misaligned_result: got %h required %h", actRes, e);
      end
    end
    tick();
    if (req_valid !== 1'b0) sawReq++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    if (req_valid !== 1'b0) sawReq++;
    nChecks++;
    if (sawReq != 0) begin
      nFails++;
      $display("[TB] FAIL misaligned_no_req: req_valid seen %0d cycles, required 0", sawReq);
    end
    nChecks++;
    if (op_ready !== 1'b1 || res_valid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL misaligned_return_idle: op_ready=%b res_valid=%b, required 1 0", op_ready, res_valid);
    end
  endtask

  task automatic test_stall();
    res_t e;
    logic [63:0] wd;
    wd = {$urandom, $urandom};
    drive_op(1'b1, 2'd3, 1'b0, 64'h4008, wd, 5'h0A);
    expQ.push_back('{data: 64'd0, tag: 5'h0A, fault: 1'b1, cause: 2'd2});
    tick();
    op_valid = 1'b0;
    op_wdata = ~wd;
    for (int i = 0; i < 5; i++) begin
      nChecks++;
      if ({req_valid, req_write, req_addr, req_wdata, req_wstrb} !==
          {1'b1, 1'b1, 64'h4008, wd, 8'hFF}) begin
        nFails++;
        $display("[TB] FAIL stall_req_stable[%0d]: valid=%b addr=%h wdata=%h wstrb=%h, required 1 4008 %h ff",
                 i, req_valid, req_addr, req_wdata, req_wstrb, wd);
      end
      tick();
    end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_fault = 1'b1;
    rsp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    rsp_valid = 1'b0;
    rsp_fault = 1'b0;
    nChecks++;
    if (res_valid !== 1'b1 || expQ.size() == 0) begin
      nFails++;
      $display("[TB] FAIL stall_bus_fault: res_valid=%b queued=%0d, required 1", res_valid, expQ.size());
    end else begin
      e = expQ.pop_front();
      if (actRes !== e) begin
        nFails++;
        $display("[TB] FAIL stall_bus_fault: got %h required %h", actRes, e);
      end
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_timeout();
    res_t e;
    int waitCycles;
    waitCycles = 0;
    drive_op(1'b0, 2'd2, 1'b1, 64'h5004, 64'h0, 5'h11);
    expQ.push_back('{data: 64'd0, tag: 5'h11, fault: 1'b1, cause: 2'd3});
    tick();
    op_valid = 1'b0;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    for (int c = 0; c < 20 && res_valid !== 1'b1; c++) begin
      if (rsp_ready === 1'b1) waitCycles++;
      tick();
    end
    nChecks++;
    if (waitCycles != int'(TO)) begin
      nFails++;
      $display("[TB] FAIL timeout_wait_cycles: got %0d required %0d", waitCycles, TO);
    end
    nChecks++;
    if (res_valid !== 1'b1 || expQ.size() == 0) begin
      nFails++;
      $display("[TB] FAIL timeout_result: res_valid=%b queued=%0d, required 1", res_valid, expQ.size());
    end else begin
      e = expQ.pop_front();
      if (actRes !== e) begin
        nFails++;
        $display("[TB] FAIL timeout_result: got %h required %h", actRes, e);
      end
    end
    nChecks++;
    if (op_ready !== 1'b0 || rsp_ready !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL timeout_stale_resp: op_ready=%b rsp_ready=%b, required 0 1", op_ready, rsp_ready);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      nChecks++;
      if ({op_ready, busy, rsp_ready} !== 3'b001) begin
        nFails++;
        $display("[TB] FAIL timeout_stale_idle[%0d]: op_ready=%b busy=%b rsp_ready=%b, required 0 0 1",
                 i, op_ready, busy, rsp_ready);
      end
      tick();
    end
    rsp_valid = 1'b1;
    rsp_rdata = 64'hDEADBEEF_CAFEF00D;
    tick();
    rsp_valid = 1'b0;
    nChecks++;
    if ({op_ready, rsp_ready, res_valid} !== 3'b100 || res_data !== 64'd0) begin
      nFails++;
      $display("[TB] FAIL timeout_drain: op_ready=%b rsp_ready=%b res_valid=%b res_data=%h, required 1 0 0 0",
               op_ready, rsp_ready, res_valid, res_data);
    end
  endtask

  task automatic test_res_backpressure();
    res_t e;
    logic [63:0] rd;
    rd = {$urandom, $urandom};
    rd[47:40] = 8'hA5;
    drive_op(1'b0, 2'd0, 1'b0, 64'h6005, 64'h0, 5'h1E);
    expQ.push_back('{data: model_load(rd, 3'd5, 2'd0, 1'b0), tag: 5'h1E, fault: 1'b0, cause: 2'd0});
    tick();
    op_valid = 1'b0;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_rdata = rd;
    tick();
    rsp_valid = 1'b0;
    rsp_rdata = ~rd;
    e = expQ[0];
    for (int i = 0; i < 3; i++) begin
      nChecks++;
      if (res_valid !== 1'b1 || actRes !== e) begin
        nFails++;
        $display("[TB] FAIL res_hold[%0d]: res_valid=%b res=%h, required 1 %h", i, res_valid, actRes, e);
      end
      tick();
    end
    res_ready = 1'b1;
    nChecks++;
    if (res_valid !== 1'b1 || expQ.size() == 0) begin
      nFails++;
      $display("[TB] FAIL res_hold_final: res_valid=%b queued=%0d, required 1", res_valid, expQ.size());
    end else begin
      e = expQ.pop_front();
      if (actRes !== e || res_data !== 64'hA5) begin
        nFails++;
        $display("[TB] FAIL res_hold_final: got %h required %h", actRes, e);
      end
    end
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    drive_op(1'b0, 2'd1, 1'b1, 64'h7002, 64'h0, 5'd2);
    tick();
    op_valid = 1'b0;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    nChecks++;
    if (busy !== 1'b1 || rsp_ready !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL reset_mid_wait_setup: busy=%b rsp_ready=%b, required 1 1", busy, rsp_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    nChecks++;
    if (op_ready !== 1'b1 || busy !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_mid_wait_ready: op_ready=%b busy=%b, required 1 0", op_ready, busy);
    end
    nChecks++;
    if ({req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready, res_valid,
         res_data, res_tag, res_fault, res_cause} !== '0) begin
      nFails++;
      $display("[TB] FAIL reset_mid_wait_outputs: req_v=%b req_addr=%h rsp_ready=%b res_v=%b res=%h, required all 0",
               req_valid, req_addr, rsp_ready, res_valid, actRes);
    end
    tick();
    rst_n = 1'b1;
    rsp_valid = 1'b1;
    rsp_rdata = 64'h1111_2222_3333_4444;
    tick();
    rsp_valid = 1'b0;
    tick();
    nChecks++;
    if ({res_valid, op_ready, busy, rsp_ready} !== 4'b0100) begin
      nFails++;
      $display("[TB] FAIL reset_mid_wait_dropped: res_valid=%b op_ready=%b busy=%b rsp_ready=%b, required 0 1 0 0",
               res_valid, op_ready, busy, rsp_ready);
    end
  endtask

  initial begin
    nChecks = 0;
    nFails  = 0;
    test_reset();
    test_signed_byte_load();
    test_half_store();
    test_misaligned();
    test_stall();
    test_timeout();
    test_res_backpressure();
    test_reset_mid_wait();
    nChecks++;
    if (expQ.size() != 0) begin
      nFails++;
      $display("[TB] FAIL scoreboard_drained: %0d results outstanding, required 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/lsu_dcache_master.md
# lsu_dcache_master

Initiator for the Z480 data-cache port. Takes one load/store micro-op at a time from the execute stage and checks alignment. It lane-shifts store data and generates byte strobes, then drives the 64-bit req/rsp dcache interface. Load data is extracted and sign/zero-extended, and one tagged result is returned to writeback, with a response watchdog.

## Interface
- TIMEOUT_CYCLES, default 255: WAIT cycles without a response before a timeout fault. 0 disables the watchdog.
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- op_valid / op_ready  in / out  1  op handshake
- op_store  in  1  1=store, 0=load
- op_size  in  2  0=byte, 1=half, 2=word, 3=dword
- op_signed  in  1  sign-extend load result
- op_addr  in  64  byte address
- op_wdata  in  64  store data, LSB-justified
- op_tag  in  5  opaque tag, returned with result
- req_valid / req_ready  out / in  1  dcache request handshake
- req_write  out  1  store request
- req_addr  out  64  op_addr with [2:0] cleared
- req_wdata  out  64  lane-shifted store data
- req_wstrb  out  8  byte strobes
- rsp_valid / rsp_ready  in / out  1  dcache response handshake
- rsp_rdata  in  64  read data, doubleword-aligned
- rsp_fault  in  1  bus fault
- res_valid / res_ready  out / in  1  writeback handshake
- res_data  out  64  extended load data; 0 for stores and faults
- res_tag  out  5  captured op_tag
- res_fault  out  1  result is faulted
- res_cause  out  2  0 none, 1 misaligned, 2 bus fault, 3 timeout
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- op_ready = (state==IDLE) && !stale. All op fields are latched on op fire.
- Misalignment rule: half with addr[0]!=0; word with addr[1:0]!=0; dword with addr[2:0]!=0.
- IDLE -> RESP on a misaligned op, with cause 1. No bus request is issued.
- IDLE -> REQ on an aligned op.
- Let off = addr[2:0] and n = 1<<size bytes.
- req_wstrb = ((1<<n)-1) << off. Loads drive the same strobes.
- req_wdata = op_wdata << (8*off), truncated to 64 bits. The value is don't-care for loads; drive it as computed.
- REQ: req_valid=1, with all req_* held stable until req_ready. On req fire -> WAIT.
- WAIT: rsp_ready=1.
  - On rsp fire with rsp_fault=1 -> RESP, cause 2, data 0.
  - On rsp fire otherwise -> RESP, cause 0.
  - Load data: x = rsp_rdata >> (8*off). Keep the low 8n bits. Sign- or zero-extend per op_signed. Stores give 0.
- Watchdog: the counter clears on entering WAIT and increments each WAIT cycle without rsp_valid.
  - At count == TIMEOUT_CYCLES -> RESP, cause 3, and set stale.
  - If rsp_valid arrives in the same cycle the limit is reached, the response wins.
- stale: while set, rsp_ready=1 in any state. The next rsp fire is discarded and clears stale.
- RESP: res_valid=1, with fields held until res_ready. On res fire -> IDLE.
- rsp_ready=0 in IDLE, REQ and RESP unless stale is set. Responses are not accepted there.

## Timing
- Reset values: state=IDLE, stale=0, counter=0.
  - Outputs: op_ready=1, busy=0.
  - All other outputs 0: req_valid, req_write, req_addr, req_wdata, req_wstrb, rsp_ready, res_valid, res_data, res_tag, res_fault, res_cause.
- All req_* and res_* outputs are registered.
- Aligned op fire in cycle N gives req_valid in N+1.
- With req_ready=1 in N+1 and rsp_valid in N+2, res_valid is asserted in N+3.
- Misaligned op fire in N gives res_valid in N+1.
- Back-to-back: with res_ready=1, res fire in cycle M returns the FSM to IDLE, so op_ready=1 in M+1.
- Reset mid-operation aborts immediately: no result, stale cleared, and the in-flight request is dropped.

## Test plan
- Signed byte load from addr 0x1003 with rsp_rdata=0x00000000_80000000:
  - Required: req_addr=0x1000, req_wstrb=0x08.
  - Required: res_data=0xFFFFFFFF_FFFFFF80, cause 0, res_valid 3 cycles after op fire.
- Half store 0xBEEF to addr 0x2006:
  - Required: req_write=1, req_wstrb=0xC0, req_wdata=0xBEEF0000_00000000.
  - Required: res_data=0.
- Word load from 0x3002:
  - Required: no req_valid ever; res_valid at N+1, res_fault=1, cause 1, res_tag preserved.
- Stall handling: req_ready held low 5 cycles, then rsp_fault=1.
  - Required: req_* stable during the stall; result cause 2, data 0.
- Timeout with TIMEOUT_CYCLES=4 and no response:
  - Required: cause 3 after 4 WAIT cycles; op_ready stays 0 until a late rsp fire is drained.
  - Required: the late data does not appear on res_data.
- res_ready held low 3 cycles:
  - Required: res_* stable throughout.
  - Required: rst_n asserted mid-WAIT returns all outputs to reset values.
